// File: rtl/return_stack_12.sv
// Return-address LIFO feeding the PC-select mux; top is combinational from
// storage and stack pointer so the popped value is visible during the pop cycle.
module return_stack_12 #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    sp;
    logic [CW-1:0]    sp_dec;
    logic [CW-1:0]    sp_next;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic             wr_en;
    logic             ov_set;
    logic             un_set;

    always_comb begin
        sp_dec  = sp - CW'(1);
        top_idx = sp_dec[AW-1:0];
        empty   = (sp == '0);
        full    = (sp == CW'(DEPTH));
        count   = sp;
        top     = empty ? '0 : mem[top_idx];
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = sp[AW-1:0];
        sp_next = sp;
        ov_set  = 1'b0;
        un_set  = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (!full) begin
                    wr_en   = 1'b1;
                    sp_next = sp + CW'(1);
                end else begin
                    ov_set = 1'b1;
                end
            end
            2'b01: begin
                if (!empty) sp_next = sp_dec;
                else        un_set  = 1'b1;
            end
            2'b11: begin
                // Simultaneous push/pop replaces the top; on an empty stack the push still lands.
                wr_en = 1'b1;
                if (!empty) begin
                    wr_idx = top_idx;
                end else begin
                    wr_idx  = '0;
                    sp_next = CW'(1);
                    un_set  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp        <= sp_next;
            overflow  <= ov_set | (overflow & ~clr_err);
            underflow <= un_set | (underflow & ~clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[wr_idx] <= push_data;
    end

endmodule

// File: tb/tb_return_stack_12.sv
// Randomized and directed checks of return_stack_12 against a queue-based LIFO model.
module tb_return_stack_12;

    localparam int DEPTH = 8;
    localparam int WIDTH = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] push_data = '0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] top;
    logic [3:0]       count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [WIDTH-1:0] model_q[$];
    logic             model_ov = 1'b0;
    logic             model_un = 1'b0;

    return_stack_12 #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .clr_err   (clr_err),
        .top       (top),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_top();
        return (model_q.size() == 0) ? '0 : model_q[$];
    endfunction

    task automatic model_update(input logic r, input logic pu, input logic po,
                                input logic [WIDTH-1:0] d, input logic clr);
        if (r) begin
            model_q.delete();
            model_ov = 1'b0;
            model_un = 1'b0;
        end else begin
            if (clr) begin
                model_ov = 1'b0;
                model_un = 1'b0;
            end
            if (pu && !po) begin
                if (model_q.size() < DEPTH) model_q.push_back(d);
                else                        model_ov = 1'b1;
            end else if (po && !pu) begin
                if (model_q.size() > 0) void'(model_q.pop_back());
                else                    model_un = 1'b1;
            end else if (pu && po) begin
                if (model_q.size() > 0) begin
                    model_q[model_q.size()-1] = d;
                end else begin
                    model_q.push_back(d);
                    model_un = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("count", 32'(count), 32'(model_q.size()));
        check("empty", 32'(empty), 32'(model_q.size() == 0));
        check("full", 32'(full), 32'(model_q.size() == DEPTH));
        check("top", 32'(top), 32'(model_top()));
        check("overflow", 32'(overflow), 32'(model_ov));
        check("underflow", 32'(underflow), 32'(model_un));
    endtask

    task automatic step(input logic r, input logic pu, input logic po,
                        input logic [WIDTH-1:0] d, input logic clr);
        @(negedge clk);
        rst = r; push = pu; pop = po; push_data = d; clr_err = clr;
        #1;
        if (po && !r) check("pop_cycle_top", 32'(top), 32'(model_top()));
        @(posedge clk);
        #1;
        model_update(r, pu, po, d, clr);
        compare_all();
    endtask

    initial begin
        int unsigned sel;

        // Reset held with a push pending: nothing may be stored.
        step(1'b1, 1'b1, 1'b0, 12'hABC, 1'b0);
        step(1'b1, 1'b1, 1'b0, 12'hABC, 1'b0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_top", 32'(top), 32'h000);
        check("rst_empty", 32'(empty), 32'd1);

        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 1'b0, 12'(12'h100 + i), 1'b0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd8);
        check("fill_top", 32'(top), 32'h108);

        step(1'b0, 1'b1, 1'b0, 12'hFFF, 1'b0);
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_top", 32'(top), 32'h108);
        check("ovf_flag", 32'(overflow), 32'd1);
        step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
        check("ovf_clr", 32'(overflow), 32'd0);

        step(1'b0, 1'b1, 1'b0, 12'h555, 1'b1);
        check("err_beats_clr", 32'(overflow), 32'd1);
        step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
        check("clr_alone", 32'(overflow), 32'd0);

        for (int i = 0; i < 8; i++) begin
            check("drain_top", 32'(top), 32'(12'h108 - i));
            step(1'b0, 1'b0, 1'b1, 12'h000, 1'b0);
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_top0", 32'(top), 32'h000);

        step(1'b0, 1'b0, 1'b1, 12'h000, 1'b0);
        check("unf_flag", 32'(underflow), 32'd1);
        check("unf_count", 32'(count), 32'd0);
        step(1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
        step(1'b0, 1'b1, 1'b1, 12'h0AA, 1'b0);
        check("pp_empty_count", 32'(count), 32'd1);
        check("pp_empty_top", 32'(top), 32'h0AA);
        check("pp_empty_unf", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, 1'b1, 12'h000, 1'b1);

        step(1'b0, 1'b1, 1'b0, 12'h010, 1'b0);
        step(1'b0, 1'b1, 1'b0, 12'h020, 1'b0);
        step(1'b0, 1'b1, 1'b1, 12'h030, 1'b0);
        check("repl_count", 32'(count), 32'd2);
        check("repl_top", 32'(top), 32'h030);
        step(1'b0, 1'b0, 1'b1, 12'h000, 1'b0);
        check("repl_pop_top", 32'(top), 32'h010);

        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 99);
            step(sel < 2,
                 (sel % 4) != 1 && sel >= 2 ? ($urandom_range(0, 2) != 0) : 1'b0,
                 ($urandom_range(0, 2) == 0) || (sel % 4 == 1),
                 12'($urandom),
                 $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
